// File: rtl/lcd_exec_arbiter.sv
// Round-robin arbiter sharing one LCD command executor among three requesters.
// Each grant runs a latch/issue/ack/done handshake, guarded by an abort timer.
module lcd_exec_arbiter #(
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [11:0] op_in,
    input  logic [23:0] data_in,
    input  logic        rdy_exe,
    output logic [3:0]  op_exe,
    output logic [7:0]  data_exe,
    output logic        exe_start,
    output logic [2:0]  gnt,
    output logic [2:0]  done,
    output logic        busy,
    output logic        timeout
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

    state_t      state;
    logic [1:0]  last_winner;
    logic [15:0] count;
    logic [15:0] count_next;
    logic [2:0]  eligible;
    logic [1:0]  cand0;
    logic [1:0]  cand1;
    logic [1:0]  cand2;
    logic [1:0]  pick;
    logic        found;

    function automatic logic [1:0] next_index(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // The requester just served still holds req during its done cycle,
    // so it is masked out to avoid a duplicate grant.
    always_comb begin
        eligible   = req & ~done;
        found      = |eligible;
        count_next = count + 16'd1;
        cand0      = next_index(last_winner);
        cand1      = next_index(cand0);
        cand2      = next_index(cand1);
        if (eligible[cand0])
            pick = cand0;
        else if (eligible[cand1])
            pick = cand1;
        else
            pick = cand2;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            gnt         <= 3'b000;
            exe_start   <= 1'b0;
            done        <= 3'b000;
            busy        <= 1'b0;
            timeout     <= 1'b0;
            op_exe      <= 4'd15;
            data_exe    <= 8'd0;
            last_winner <= 2'd2;
            count       <= 16'd0;
        end else begin
            exe_start <= 1'b0;
            done      <= 3'b000;
            case (state)
                IDLE: begin
                    if (found && rdy_exe) begin
                        last_winner <= pick;
                        gnt         <= 3'b001 << pick;
                        op_exe      <= op_in[{pick, 2'b00} +: 4];
                        data_exe    <= data_in[{pick, 3'b000} +: 8];
                        exe_start   <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    count <= 16'd0;
                    state <= WAIT_ACK;
                end
                WAIT_ACK, WAIT_DONE: begin
                    count <= count_next;
                    // A genuine completion wins over an abort landing on the same edge.
                    if (state == WAIT_DONE && rdy_exe) begin
                        done  <= gnt;
                        gnt   <= 3'b000;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (count_next == TIMEOUT) begin
                        timeout <= 1'b1;
                        done    <= gnt;
                        gnt     <= 3'b000;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else if (state == WAIT_ACK && !rdy_exe) begin
                        state <= WAIT_DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_exec_arbiter.sv
// Self-checking bench for lcd_exec_arbiter: the bench acts as requesters and
// executor, predicting winners and completion cycles at transaction level.
module tb_lcd_exec_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [11:0] op_in = 12'd0;
    logic [23:0] data_in = 24'd0;
    logic        rdy_exe = 1'b1;
    logic [3:0]  op_exe;
    logic [7:0]  data_exe;
    logic        exe_start;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic        busy;
    logic        timeout;

    int          errors = 0;
    int          checks = 0;
    int          last_w;
    logic [2:0]  just_done;
    logic        exp_to;

    lcd_exec_arbiter #(.TIMEOUT(16'd8)) dut (
        .clk(clk), .rst(rst), .req(req), .op_in(op_in), .data_in(data_in),
        .rdy_exe(rdy_exe), .op_exe(op_exe), .data_exe(data_exe),
        .exe_start(exe_start), .gnt(gnt), .done(done), .busy(busy),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first pending index after the previous winner.
    function automatic int rr_pick(input logic [2:0] mask, input int last);
        for (int k = 1; k <= 3; k++) begin
            if (mask[(last + k) % 3])
                return (last + k) % 3;
        end
        return -1;
    endfunction

    task automatic check_reset_values(input string tag);
        check_output({tag, "_gnt"}, 32'(gnt), 32'd0);
        check_output({tag, "_start"}, 32'(exe_start), 32'd0);
        check_output({tag, "_done"}, 32'(done), 32'd0);
        check_output({tag, "_busy"}, 32'(busy), 32'd0);
        check_output({tag, "_timeout"}, 32'(timeout), 32'd0);
        check_output({tag, "_op"}, 32'(op_exe), 32'd15);
        check_output({tag, "_data"}, 32'(data_exe), 32'd0);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #1;
        check_reset_values("reset_async");
        tick();
        tick();
        rst = 1'b1;
        last_w    = 2;
        just_done = 3'b000;
        exp_to    = 1'b0;
    endtask

    task automatic idle_cycle(input string tag);
        tick();
        just_done = 3'b000;
        check_output({tag, "_gnt"}, 32'(gnt), 32'd0);
        check_output({tag, "_start"}, 32'(exe_start), 32'd0);
        check_output({tag, "_done"}, 32'(done), 32'd0);
        check_output({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // ack_dly = 0 means the executor never drops ready (forces an abort).
    task automatic apply_stimulus(input int ack_dly, input int busy_len,
                                  input bit drop_req, input bit hold_req);
        int         w;
        int         total;
        int         end_n;
        logic [3:0] eop;
        logic [7:0] edat;
        w    = rr_pick(req & ~just_done, last_w);
        eop  = op_in[w*4 +: 4];
        edat = data_in[w*8 +: 8];
        tick();
        just_done = 3'b000;
        check_output("issue_start", 32'(exe_start), 32'd1);
        check_output("issue_gnt", 32'(gnt), 32'(3'b001 << w));
        check_output("issue_op", 32'(op_exe), 32'(eop));
        check_output("issue_data", 32'(data_exe), 32'(edat));
        check_output("issue_busy", 32'(busy), 32'd1);
        check_output("issue_done", 32'(done), 32'd0);
        last_w = w;
        total  = (ack_dly == 0) ? TO + 1 : ack_dly + busy_len;
        end_n  = (total < TO) ? total : TO;
        for (int n = 1; n <= end_n; n++) begin
            tick();
            check_output("wait_start", 32'(exe_start), 32'd0);
            check_output("wait_done", 32'(done), 32'd0);
            check_output("wait_gnt", 32'(gnt), 32'(3'b001 << w));
            check_output("wait_busy", 32'(busy), 32'd1);
            check_output("wait_op", 32'(op_exe), 32'(eop));
            check_output("wait_data", 32'(data_exe), 32'(edat));
            rdy_exe = (ack_dly != 0 && n >= ack_dly && n < ack_dly + busy_len) ? 1'b0 : 1'b1;
            op_in   = 12'($urandom);
            data_in = 24'($urandom);
            if (drop_req && n == 1)
                req[w] = 1'b0;
        end
        if (total > TO)
            exp_to = 1'b1;
        tick();
        check_output("end_done", 32'(done), 32'(3'b001 << w));
        check_output("end_gnt", 32'(gnt), 32'd0);
        check_output("end_busy", 32'(busy), 32'd0);
        check_output("end_start", 32'(exe_start), 32'd0);
        check_output("end_timeout", 32'(timeout), 32'(exp_to));
        check_output("end_op", 32'(op_exe), 32'(eop));
        check_output("end_data", 32'(data_exe), 32'(edat));
        rdy_exe = 1'b1;
        if (!hold_req)
            req[w] = 1'b0;
        just_done = 3'b001 << w;
    endtask

    initial begin
        last_w    = 2;
        just_done = 3'b000;
        exp_to    = 1'b0;
        #1;
        apply_reset();

        // Single request from requester 0
        req = 3'b001; op_in = 12'h001; data_in = 24'h000005;
        apply_stimulus(1, 3, 1'b0, 1'b0);
        idle_cycle("single_after");

        // Executor busy: no grant until ready returns
        req = 3'b010; op_in = 12'h3A0; data_in = 24'h00C300; rdy_exe = 1'b0;
        for (int i = 0; i < 10; i++)
            idle_cycle("notready");
        rdy_exe = 1'b1;
        apply_stimulus(2, 2, 1'b0, 1'b0);

        // Contention from reset: grant order 0,1,2,0
        apply_reset();
        req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            op_in   = 12'($urandom);
            data_in = 24'($urandom);
            apply_stimulus(1, 2, 1'b0, 1'b1);
        end
        req = 3'b000;
        idle_cycle("contention_after");

        // Random traffic with dropped requests and toggling inputs mid-flight
        for (int t = 0; t < 14; t++) begin
            if (just_done != 3'b000 && $urandom_range(0, 1) == 1) begin
                req = 3'b000;
                idle_cycle("random_gap");
            end
            do
                req = 3'($urandom_range(1, 7));
            while ((req & ~just_done) == 3'b000);
            op_in   = 12'($urandom);
            data_in = 24'($urandom);
            apply_stimulus(int'($urandom_range(1, 3)), int'($urandom_range(1, 4)),
                           1'($urandom_range(0, 1)), 1'b0);
        end

        // Abort when the executor never acknowledges, then normal service
        req = 3'b000;
        idle_cycle("pre_timeout");
        req = 3'b100; op_in = 12'h700; data_in = 24'h5A0000;
        apply_stimulus(0, 0, 1'b0, 1'b0);
        req = 3'b001; op_in = 12'h009; data_in = 24'h0000E1;
        apply_stimulus(1, 1, 1'b0, 1'b0);
        idle_cycle("post_timeout");
        check_output("timeout_sticky", 32'(timeout), 32'd1);

        // Reset while the executor is running
        req = 3'b001; op_in = 12'h004; data_in = 24'h000077;
        tick();
        tick();
        rdy_exe = 1'b0;
        tick();
        tick();
        check_output("midop_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_reset_values("midop_async");
        rdy_exe = 1'b1;
        tick();
        check_output("midop_nodone", 32'(done), 32'd0);
        rst = 1'b1;
        last_w    = 2;
        just_done = 3'b000;
        exp_to    = 1'b0;
        req = 3'b110; op_in = 12'($urandom); data_in = 24'($urandom);
        apply_stimulus(1, 2, 1'b0, 1'b0);
        apply_stimulus(2, 1, 1'b0, 1'b0);
        req = 3'b000;
        idle_cycle("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_exec_arbiter.md
LCD_EXEC_ARBITER -- requirements
Module: lcd_exec_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 16'd50000, max cycles a granted transaction may wait on the executor before abort.
REQ-002 clk  input  1  single clock; all sequential logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 req  input  3  per-requester request; bit i held high by requester i until its done[i].
REQ-005 op_in  input  12  requester i operation at op_in[4i+3:4i].
REQ-006 data_in  input  24  requester i data byte at data_in[8i+7:8i].
REQ-007 rdy_exe  input  1  executor ready; high = idle, low = executing.
REQ-008 op_exe  output  4  operation driven to the executor.
REQ-009 data_exe  output  8  data driven to the executor.
REQ-010 exe_start  output  1  one-cycle strobe launching the executor.
REQ-011 gnt  output  3  one-hot grant; zero when idle.
REQ-012 done  output  3  one-cycle completion pulse for the granted requester.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 timeout  output  1  sticky abort flag; cleared only by reset.

Function
REQ-015 The state machine SHALL have the states IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
REQ-016 IDLE: if req != 0 and rdy_exe = 1, the block SHALL select a winner, set gnt, latch that requester's op/data into op_exe/data_exe, and go to ISSUE at the same edge; otherwise it SHALL remain in IDLE.
REQ-017 Arbitration SHALL be round-robin: search starts at index (last_winner + 1) mod 3; last_winner resets to 2, so requester 0 has first priority after reset.
REQ-018 ISSUE SHALL last exactly one cycle, with exe_start = 1, then go to WAIT_ACK; exe_start SHALL be 0 in every other state.
REQ-019 WAIT_ACK: on rdy_exe = 0, go to WAIT_DONE.
REQ-020 WAIT_DONE: on rdy_exe = 1, assert done[winner] for one cycle, clear gnt, and return to IDLE at the same edge.
REQ-021 op_exe/data_exe SHALL stay constant from latch until the return to IDLE; afterwards they retain their last value.
REQ-022 The timeout counter (16 bit):
- clears on entry to WAIT_ACK;
- increments each cycle in WAIT_ACK and WAIT_DONE;
- on reaching TIMEOUT, the block SHALL set timeout = 1, pulse done[winner], clear gnt, and return to IDLE.
REQ-023 Request latency: done SHALL be at the earliest 4 cycles after the req-sampling edge (latch, ISSUE, ACK, DONE).
REQ-024 If req[winner] is dropped mid-transaction, the block SHALL ignore it and complete normally, including the done pulse.
REQ-025 Changes on req/op_in/data_in while busy SHALL NOT affect the current transaction.
REQ-026 In IDLE with rdy_exe = 0, no grant SHALL be issued even if req != 0.
REQ-027 A requester re-raising req in the cycle after its done SHALL be arbitrated normally and lose to any other pending requester.
REQ-028 No back-to-back grant: the block SHALL spend at least one cycle in IDLE between transactions.

Reset
REQ-029 On rst = 0, the block SHALL immediately, without waiting for a clock edge, set:
- state = IDLE, gnt = 0, exe_start = 0, done = 0, busy = 0, timeout = 0;
- op_exe = 4'd15 (idle op), data_exe = 8'd0;
- last_winner = 2, counter = 0.
REQ-030 Reset mid-transaction SHALL abort the transaction with no done pulse; the requester SHALL re-request.

Verification
REQ-031 Single request: req=001, op_in[3:0]=4'd1, data_in[7:0]=8'h05, executor drops ready 1 cycle after exe_start and raises it 3 cycles later -> op_exe=1, data_exe=05, exactly one exe_start, then done=001 one cycle, gnt=000.
REQ-032 Contention: req=111 held -> grant order 0,1,2,0, with each done before the next exe_start.
REQ-033 Executor not ready: req=010 with rdy_exe=0 for 10 cycles -> gnt stays 000 and exe_start stays 0; the grant follows the first cycle rdy_exe=1.
REQ-034 Timeout with TIMEOUT=8: rdy_exe never falls after exe_start -> 8 cycles later done pulses, timeout=1 and stays 1, block accepts the next request.
REQ-035 Reset mid-op: rst low during WAIT_DONE -> all outputs at reset values asynchronously, no done pulse; after release, req=100 is granted first only if no lower index is pending.
REQ-036 Data stability: op_in/data_in toggled every cycle during WAIT_DONE -> op_exe/data_exe unchanged until done.
